reg_bank_writer: RTL



---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_writer_onehot_dec.sv | 23 ++
 rtl/reg_bank_writer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the 8-entry x 2-bit register bank (writer and read mux).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_bank_pkg;

    localparam int NUM_REGS = 8;                 // bank depth, power of two
    localparam int DATA_W   = 2;                 // bits per entry
    localparam int ADDR_W   = $clog2(NUM_REGS);  // entry address width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

    typedef logic [DATA_W-1:0] entry_t;

endpackage

// File: rtl/reg_bank_writer_onehot_dec.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies with en.
// Ports: en (decode enable), sel (binary index), onehot (2**IN_W strobe vector).
module onehot_dec
    import reg_bank_pkg::*;
#(
    parameter int IN_W  = ADDR_W,
    parameter int OUT_W = 1 << IN_W
) (
    input  logic             en,
    input  logic [IN_W-1:0]  sel,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_writer.sv
// Burst write controller for the register bank: command + beat stream -> one-hot strobes + shadow copy.
// Latency: beat accepted at edge N -> w_en/wd during cycle N+1 -> bank_q updated after edge N+1.
// Backpressure: cmd_ready only in IDLE, data_ready only in BURST; both decoded from state alone.
// Ports:
//   clk, ar_n           clock, synchronous active-low reset
//   cmd_valid/ready     burst command handshake; cmd_addr = first entry, cmd_len = beats-1
//   data_valid/ready    beat handshake; data_in = beat payload
//   w_en, wd            registered one-hot write strobe and write data for the bank
//   bank_q              packed shadow of the bank, entry k at [DATA_W*k +: DATA_W]
//   busy, done          busy in BURST/DONE; done is a one-cycle end-of-burst pulse
module reg_bank_writer
    import reg_bank_pkg::*;
(
    input  logic                       clk,
    input  logic                       ar_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [ADDR_W-1:0]          cmd_len,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  entry_t                     data_in,
    output logic [NUM_REGS-1:0]        w_en,
    output entry_t                     wd,
    output logic [NUM_REGS*DATA_W-1:0] bank_q,
    output logic                       busy,
    output logic                       done
);

    wr_state_t             state_q;
    wr_state_t             state_d;
    logic [ADDR_W-1:0]     ptr_q;
    logic [ADDR_W-1:0]     rem_q;
    logic                  cmd_hs;
    logic                  beat_hs;
    logic [NUM_REGS-1:0]   w_en_d;

    assign cmd_hs  = cmd_valid & cmd_ready;
    assign beat_hs = data_valid & data_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!ar_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded handshake/status outputs
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (data_valid && (rem_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write pointer and remaining-beat counter. The pointer wraps naturally
    // at ADDR_W bits, which gives address-order overwrite for wrapped bursts.
    always_ff @(posedge clk) begin
        if (!ar_n) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else if (cmd_hs) begin
            ptr_q <= cmd_addr;
            rem_q <= cmd_len;
        end else if (beat_hs) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (rem_q != '0) begin
                rem_q <= rem_q - ADDR_W'(1);
            end
        end
    end

    onehot_dec #(
        .IN_W  (ADDR_W),
        .OUT_W (NUM_REGS)
    ) u_dec (
        .en     (beat_hs),
        .sel    (ptr_q),
        .onehot (w_en_d)
    );

    // Registered write port: strobe lasts exactly the cycle after the beat.
    always_ff @(posedge clk) begin
        if (!ar_n) begin
            w_en <= '0;
            wd   <= '0;
        end else begin
            w_en <= w_en_d;
            if (beat_hs) begin
                wd <= data_in;
            end
        end
    end

    // Shadow bank follows the same edge the external bank uses for w_en/wd,
    // so a reset on that edge cancels the pending write in both.
    always_ff @(posedge clk) begin
        if (!ar_n) begin
            bank_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_en[k]) begin
                    bank_q[k*DATA_W +: DATA_W] <= wd;
                end
            end
        end
    end

endmodule
